// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and
// default per-operation latencies.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_div.sv
// Combinational signed/unsigned divider. Signed division truncates toward
// zero and the remainder follows the dividend's sign. MIN_INT / -1 yields
// MIN_INT with zero remainder; divide by zero is flagged and outputs zero.
module md_div
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    // Divide magnitudes, then restore signs; special cases override.
    always_comb begin
        div_zero = (b == '0);
        a_neg    = is_signed & a[WIDTH-1];
        b_neg    = is_signed & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        q_mag    = '0;
        r_mag    = '0;
        quot     = '0;
        rem      = '0;
        if (div_zero) begin
            quot = '0;
            rem  = '0;
        end else if (is_signed && (a == MIN_INT) && (b == '1)) begin
            quot = MIN_INT;
            rem  = '0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
            rem   = a_neg ? -r_mag : r_mag;
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at accept into shadow registers and committed to
// HI/LO when the latency counter expires. Define MDU_MADD_EN to enable
// the multiply-accumulate/subtract operations.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   hi_n;
    logic [WIDTH-1:0]   lo_n;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   div_quot;
    logic [WIDTH-1:0]   div_rem;
    logic               div_by_zero;

    assign busy = (counter != '0);

    // Full-width products; sign extension gives the signed product in the low 2*WIDTH bits.
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    md_div #(
        .WIDTH(WIDTH)
    ) u_div (
        .a        (a),
        .b        (b),
        .is_signed(md_op == MD_DIV),
        .quot     (div_quot),
        .rem      (div_rem),
        .div_zero (div_by_zero)
    );

`ifdef MDU_MADD_EN
    logic [2*WIDTH-1:0] acc;

    // Accumulate/subtract against HI/LO as they stand at the accept edge.
    always_comb begin
        case (md_op)
            MD_MADDU: acc = {hi, lo} + prod_u;
            MD_MSUB:  acc = {hi, lo} - prod_s;
            MD_MSUBU: acc = {hi, lo} - prod_u;
            default:  acc = {hi, lo} + prod_s;
        endcase
    end
`endif

    // Accept ops when idle, count down latency, commit shadow on expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter  <= '0;
            hi       <= '0;
            lo       <= '0;
            hi_n     <= '0;
            lo_n     <= '0;
            div_zero <= 1'b0;
        end else if (busy) begin
            counter <= counter - CW'(1);
            if (counter == CW'(1)) begin
                hi <= hi_n;
                lo <= lo_n;
            end
        end else if (start) begin
            case (md_op)
                MD_MULT: begin
                    {hi_n, lo_n} <= prod_s;
                    counter      <= CW'(MULT_CYCLES);
                    div_zero     <= 1'b0;
                end
                MD_MULTU: begin
                    {hi_n, lo_n} <= prod_u;
                    counter      <= CW'(MULT_CYCLES);
                    div_zero     <= 1'b0;
                end
                MD_DIV, MD_DIVU: begin
                    // Divide by zero keeps HI/LO by committing their current values.
                    if (div_by_zero) begin
                        hi_n <= hi;
                        lo_n <= lo;
                    end else begin
                        hi_n <= div_rem;
                        lo_n <= div_quot;
                    end
                    counter  <= CW'(DIV_CYCLES);
                    div_zero <= div_by_zero;
                end
                MD_MTHI: begin
                    hi       <= a;
                    div_zero <= 1'b0;
                end
                MD_MTLO: begin
                    lo       <= a;
                    div_zero <= 1'b0;
                end
`ifdef MDU_MADD_EN
                MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                    {hi_n, lo_n} <= acc;
                    counter      <= CW'(MULT_CYCLES);
                    div_zero     <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed scenarios followed by random operations,
// all checked against a behavioural model of HI/LO, latency and div_zero.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int checks;
    int errors;

    // Reference model state
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;
    int          m_left;
    bit          m_dz;

    md_unit #(
        .WIDTH(32),
        .MULT_CYCLES(MC),
        .DIV_CYCLES(DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hi   = '0;
        m_lo   = '0;
        m_pend = '0;
        m_left = 0;
        m_dz   = 1'b0;
    endtask

    // Behaviour of one rising edge, expressed with plain arithmetic.
    task automatic model_edge(input bit st, input logic [3:0] op,
                              input logic [31:0] av, input logic [31:0] bv);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     ps, pu;
        sa = $signed(av);
        sb = $signed(bv);
        ua = av;
        ub = bv;
        ps = sa * sb;
        pu = ua * ub;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) {m_hi, m_lo} = m_pend;
        end else if (st) begin
            case (op)
                4'd1: begin m_pend = ps; m_left = MC; m_dz = 1'b0; end
                4'd2: begin m_pend = pu; m_left = MC; m_dz = 1'b0; end
                4'd3, 4'd4: begin
                    m_left = DC;
                    if (bv == 0) begin
                        m_pend = {m_hi, m_lo};
                        m_dz   = 1'b1;
                    end else begin
                        m_dz = 1'b0;
                        if (op == 4'd3) begin
                            sq = sa / sb;
                            sr = sa % sb;
                            m_pend = {sr[31:0], sq[31:0]};
                        end else begin
                            m_pend = {32'(ua % ub), 32'(ua / ub)};
                        end
                    end
                end
                4'd5: begin m_hi = av; m_dz = 1'b0; end
                4'd6: begin m_lo = av; m_dz = 1'b0; end
`ifdef MDU_MADD_EN
                4'd7:  begin m_pend = {m_hi, m_lo} + ps; m_left = MC; m_dz = 1'b0; end
                4'd8:  begin m_pend = {m_hi, m_lo} + pu; m_left = MC; m_dz = 1'b0; end
                4'd9:  begin m_pend = {m_hi, m_lo} - ps; m_left = MC; m_dz = 1'b0; end
                4'd10: begin m_pend = {m_hi, m_lo} - pu; m_left = MC; m_dz = 1'b0; end
`endif
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".busy"}, 64'(busy), 64'(m_left != 0));
        check({tag, ".hi"}, 64'(hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(lo), 64'(m_lo));
        check({tag, ".div_zero"}, 64'(div_zero), 64'(m_dz));
    endtask

    task automatic step(input string tag, input bit st, input logic [3:0] op,
                        input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = st;
        md_op = op;
        a     = av;
        b     = bv;
        @(posedge clk);
        model_edge(st, op, av, bv);
        #1;
        compare_all(tag);
        $display("step %-8s start=%0b op=%0d a=%h b=%h -> busy=%0b hi=%h lo=%h dz=%0b",
                 tag, st, op, av, bv, busy, hi, lo, div_zero);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 4'd0, 32'h0, 32'h0);
    endtask

    // Counts busy cycles following an accept; ends in the first idle cycle.
    task automatic count_busy(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (busy && n < 50) begin
            n++;
            step(tag, 1'b0, 4'd0, 32'h0, 32'h0);
        end
        check({tag, ".busy_cycles"}, 64'(n), 64'(exp_cycles));
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'(($urandom_range(0, 15)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = 4'd0;
        a      = '0;
        b      = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Signed and unsigned multiply
        step("mult", 1'b1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        count_busy("mult", MC);
        check("mult.hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        check("mult.lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFE);
        step("multu", 1'b1, 4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        count_busy("multu", MC);
        check("multu.hi_const", 64'(hi), 64'h0000_0000_0000_0001);

        // Signed and unsigned divide
        step("div", 1'b1, 4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        count_busy("div", DC);
        check("div.lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        check("div.hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        step("divu", 1'b1, 4'd4, 32'h0000_0007, 32'h0000_0002);
        count_busy("divu", DC);

        // Divide by zero preserves HI/LO and raises the sticky flag
        step("mthi", 1'b1, 4'd5, 32'h0000_1234, 32'h0);
        step("divz", 1'b1, 4'd3, 32'h0000_0055, 32'h0);
        count_busy("divz", DC);
        check("divz.hi_const", 64'(hi), 64'h0000_0000_0000_1234);
        step("minint", 1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy("minint", DC);
        check("minint.lo_const", 64'(lo), 64'h0000_0000_8000_0000);

        // Start while busy is ignored; issue in the cycle busy falls
        step("div2", 1'b1, 4'd3, 32'h0000_0064, 32'h0000_0007);
        step("ignmult", 1'b1, 4'd1, 32'h0000_0003, 32'h0000_0003);
        count_busy("div2", DC - 1);
        step("b2bmult", 1'b1, 4'd1, 32'h0000_0006, 32'h0000_0007);
        count_busy("b2bmult", MC);

        // Asynchronous reset mid-operation aborts without a late commit
        step("rstmult", 1'b1, 4'd1, 32'h0000_0011, 32'h0000_0013);
        idle("rstmult", 2);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("asyncrst");
        @(negedge clk);
        reset = 1'b0;
        idle("postrst", MC + 2);

        // Accumulate operations (or no effect when the option is absent)
        step("mthi0", 1'b1, 4'd5, 32'h0, 32'h0);
        step("mtlo10", 1'b1, 4'd6, 32'd10, 32'h0);
        step("madd", 1'b1, 4'd7, 32'd3, 32'd4);
        idle("madd", MC);
`ifdef MDU_MADD_EN
        check("madd.lo_const", 64'(lo), 64'd22);
`endif
        step("msubu", 1'b1, 4'd10, 32'd1, 32'd30);
        idle("msubu", MC);
`ifdef MDU_MADD_EN
        check("msubu.hilo_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF8);
`else
        check("msubu.hilo_const", {hi, lo}, 64'h0000_0000_0000_000A);
`endif
        step("nop15", 1'b1, 4'd15, 32'h1, 32'h1);

        // Random operations, including starts while busy
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 rand_operand(), rand_operand());
        end
        idle("drain", DC + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
